// File: rtl/vram_host_master_if.sv
// vram_host_master_if
//   Bundles the command handshake, the VRAM host bus and the read response
//   of vram_host_master.
//
//   Handshake: a command transfers on a clk edge where reqValid and reqReady
//   are both high. reqReady is high only while the master is idle and out of
//   reset. Request inputs are sampled only on that edge; anything presented
//   while the master is busy is ignored, not queued.
//
//   Modports:
//     master : the vram_host_master side (consumes commands, drives the bus)
//     slave  : the opposite side (issues commands, returns bus read data)
//
//   dbgState exposes the master's FSM state (IDLE=0, SETUP=1, STROBE=2, HOLD=3).
interface vram_host_master_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [12:0] reqAddr;
  logic [7:0]  reqData;
  logic [12:0] reqLen;
  logic [12:0] busAddr;
  logic [7:0]  busDataOut;
  logic        busDataOe;
  logic [7:0]  busDataIn;
  logic        nBusRd;
  logic        nBusWr;
  logic        rspValid;
  logic [7:0]  rspData;
  logic        busy;
  logic [1:0]  dbgState;

  modport master (
    input  reqValid, reqWrite, reqAddr, reqData, reqLen, busDataIn,
    output reqReady, busAddr, busDataOut, busDataOe, nBusRd, nBusWr,
           rspValid, rspData, busy, dbgState
  );

  modport slave (
    output reqValid, reqWrite, reqAddr, reqData, reqLen, busDataIn,
    input  reqReady, busAddr, busDataOut, busDataOe, nBusRd, nBusWr,
           rspValid, rspData, busy, dbgState
  );
endinterface

// File: rtl/vram_host_master.sv
// vram_host_master
//   Drives the VGA board's asynchronous host port. Every byte transfer is a
//   SETUP / STROBE / HOLD sequence with programmable cycle counts. Reads move a
//   single byte; writes move reqLen+1 bytes to consecutive addresses (wrapping
//   at 8 KiB) with no idle cycles between them.
//
//   Ports:
//     clk   : system clock
//     nrst  : synchronous active-low reset
//     bus   : vram_host_master_if.master (command, host bus, read response,
//             dbgState)
//
//   Every output except reqReady is a flop. The output flops are loaded from
//   the next-state decode, so a strobe is low for exactly the cycles the FSM
//   spends in STROBE.
module vram_host_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input logic              clk,
  input logic              nrst,
  vram_host_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

  state_t      state, nextState;
  logic [3:0]  phase, phaseNext;
  logic [12:0] count, countNext;
  logic        isWrite, writeNext;
  logic [12:0] addrNext;
  logic [7:0]  dataNext;
  logic [7:0]  rspDataNext;
  logic        rspValidNext;
  logic        accept;

  assign bus.reqReady = (state == IDLE) && nrst;
  assign accept       = bus.reqValid && bus.reqReady;
  assign bus.dbgState = state;

  always_comb begin
    nextState    = state;
    phaseNext    = phase + 4'd1;
    countNext    = count;
    writeNext    = isWrite;
    addrNext     = bus.busAddr;
    dataNext     = bus.busDataOut;
    rspDataNext  = bus.rspData;
    rspValidNext = 1'b0;

    case (state)
      IDLE: begin
        phaseNext = 4'd0;
        if (accept) begin
          nextState = SETUP;
          addrNext  = bus.reqAddr;
          dataNext  = bus.reqData;
          writeNext = bus.reqWrite;
          // The length only matters for writes; a read is always one byte.
          countNext = bus.reqWrite ? bus.reqLen : 13'd0;
        end
      end
      SETUP: begin
        if (phase == SETUP_LAST) begin
          nextState = STROBE;
          phaseNext = 4'd0;
        end
      end
      STROBE: begin
        if (phase == STROBE_LAST) begin
          nextState = HOLD;
          phaseNext = 4'd0;
          // Capture on the edge that closes the strobe; the pulse lands in
          // the first HOLD cycle.
          if (!isWrite) begin
            rspDataNext  = bus.busDataIn;
            rspValidNext = 1'b1;
          end
        end
      end
      HOLD: begin
        if (phase == HOLD_LAST) begin
          phaseNext = 4'd0;
          if (isWrite && (count != 13'd0)) begin
            nextState = SETUP;
            countNext = count - 13'd1;
            addrNext  = bus.busAddr + 13'd1;  // 13-bit wrap gives modulo 8192
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: begin
        nextState = IDLE;
        phaseNext = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state          <= IDLE;
      phase          <= 4'd0;
      count          <= 13'd0;
      isWrite        <= 1'b0;
      bus.busAddr    <= 13'd0;
      bus.busDataOut <= 8'd0;
      bus.busDataOe  <= 1'b0;
      bus.nBusRd     <= 1'b1;
      bus.nBusWr     <= 1'b1;
      bus.rspValid   <= 1'b0;
      bus.rspData    <= 8'd0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= nextState;
      phase          <= phaseNext;
      count          <= countNext;
      isWrite        <= writeNext;
      bus.busAddr    <= addrNext;
      bus.busDataOut <= dataNext;
      bus.busDataOe  <= (nextState != IDLE) && writeNext;
      // Both strobes decode from the same state with opposite direction
      // terms, so they can never be low together.
      bus.nBusRd     <= !((nextState == STROBE) && !writeNext);
      bus.nBusWr     <= !((nextState == STROBE) && writeNext);
      bus.rspValid   <= rspValidNext;
      bus.rspData    <= rspDataNext;
      bus.busy       <= (nextState != IDLE);
    end
  end

endmodule

// File: tb/tb_vram_host_master.sv
module tb_vram_host_master;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; reqValid is steered to the selected instance only.
  int          sel = 0;
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [12:0] reqAddr = '0;
  logic [7:0]  reqData = '0;
  logic [12:0] reqLen = '0;
  logic [7:0]  busDataIn = '0;

  vram_host_master_if ifA ();
  vram_host_master_if ifB ();
  vram_host_master_if ifC ();

  assign ifA.reqValid = reqValid && (sel == 0);
  assign ifB.reqValid = reqValid && (sel == 1);
  assign ifC.reqValid = reqValid && (sel == 2);
  assign ifA.reqWrite = reqWrite;  assign ifB.reqWrite = reqWrite;  assign ifC.reqWrite = reqWrite;
  assign ifA.reqAddr  = reqAddr;   assign ifB.reqAddr  = reqAddr;   assign ifC.reqAddr  = reqAddr;
  assign ifA.reqData  = reqData;   assign ifB.reqData  = reqData;   assign ifC.reqData  = reqData;
  assign ifA.reqLen   = reqLen;    assign ifB.reqLen   = reqLen;    assign ifC.reqLen   = reqLen;
  assign ifA.busDataIn = busDataIn; assign ifB.busDataIn = busDataIn; assign ifC.busDataIn = busDataIn;

  vram_host_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(4), .HOLD_CYCLES(2))
    dut (.clk(clk), .nrst(nrst), .bus(ifA));
  vram_host_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1))
    dutFast (.clk(clk), .nrst(nrst), .bus(ifB));
  vram_host_master #(.SETUP_CYCLES(15), .STROBE_CYCLES(15), .HOLD_CYCLES(15))
    dutSlow (.clk(clk), .nrst(nrst), .bus(ifC));

  int pSetup[3]  = '{2, 1, 15};
  int pStrobe[3] = '{4, 1, 15};
  int pHold[3]   = '{2, 1, 15};

  // Observed outputs of the selected instance.
  logic        oReady, oBusy, oOe, oRd, oWr, oRv;
  logic [12:0] oAddr;
  logic [7:0]  oDout, oRsp;

  always_comb begin
    oReady = ifA.reqReady; oBusy = ifA.busy; oOe = ifA.busDataOe;
    oRd = ifA.nBusRd; oWr = ifA.nBusWr; oRv = ifA.rspValid;
    oAddr = ifA.busAddr; oDout = ifA.busDataOut; oRsp = ifA.rspData;
    case (sel)
      1: begin
        oReady = ifB.reqReady; oBusy = ifB.busy; oOe = ifB.busDataOe;
        oRd = ifB.nBusRd; oWr = ifB.nBusWr; oRv = ifB.rspValid;
        oAddr = ifB.busAddr; oDout = ifB.busDataOut; oRsp = ifB.rspData;
      end
      2: begin
        oReady = ifC.reqReady; oBusy = ifC.busy; oOe = ifC.busDataOe;
        oRd = ifC.nBusRd; oWr = ifC.nBusWr; oRv = ifC.rspValid;
        oAddr = ifC.busAddr; oDout = ifC.busDataOut; oRsp = ifC.rspData;
      end
      default: ;
    endcase
  end

  // Reference model state per instance: last bus address and last read byte.
  logic [12:0] mAddr[3];
  logic [7:0]  mRsp[3];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (inst %0d): got 0x%0h expected 0x%0h at %0t", name, sel, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      mAddr[i] = '0;
      mRsp[i]  = '0;
    end
  endtask

  // Issue one command on the selected instance and check every cycle from
  // T1 to the first idle cycle against a timeline computed from the
  // transfer period arithmetic. Returns at the first idle cycle with
  // reqValid low, so a following call is accepted in that cycle.
  task automatic doCmd(input bit write, input logic [12:0] addr, input logic [7:0] data,
                       input logic [12:0] len, input logic [7:0] rd, input bit noise,
                       output int pulses);
    int s, st, p, xfers, total, k, o, guard;
    bit inStrobe, prevStrobe, cur;
    s = pSetup[sel];
    st = pStrobe[sel];
    p = s + st + pHold[sel];
    xfers = write ? int'(len) + 1 : 1;
    total = p * xfers + 1;
    guard = 0;
    while (!oReady && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_cmd", oReady, 1);
    reqValid = 1'b1; reqWrite = write; reqAddr = addr; reqData = data; reqLen = len;
    busDataIn = ~rd;
    @(posedge clk); #1;
    pulses = 0;
    prevStrobe = 1'b1;
    for (int n = 1; n <= total; n++) begin
      if (n <= p * xfers) begin
        k = (n - 1) / p;
        o = (n - 1) % p + 1;
        inStrobe = (o > s) && (o <= s + st);
        if (!write && o == s + st + 1) mRsp[sel] = rd;
        chk("busy", oBusy, 1);
        chk("reqReady_busy", oReady, 0);
        chk("busAddr", oAddr, 32'((int'(addr) + k) % 8192));
        chk("busDataOe", oOe, write);
        if (write) chk("busDataOut", oDout, data);
        chk("nBusWr", oWr, !(write && inStrobe));
        chk("nBusRd", oRd, !(!write && inStrobe));
        chk("rspValid", oRv, (!write && o == s + st + 1));
        chk("rspData", oRsp, mRsp[sel]);
        busDataIn = (!write && o == s + st) ? rd : ~rd;
        if (noise) begin
          reqValid = 1'($urandom_range(0, 1));
          reqWrite = 1'($urandom_range(0, 1));
          reqAddr  = 13'($urandom);
          reqData  = 8'($urandom);
          reqLen   = 13'($urandom_range(0, 7));
        end else begin
          reqValid = 1'b0;
        end
      end else begin
        mAddr[sel] = 13'((int'(addr) + xfers - 1) % 8192);
        chk("idle_busy", oBusy, 0);
        chk("idle_reqReady", oReady, 1);
        chk("idle_busDataOe", oOe, 0);
        chk("idle_nBusWr", oWr, 1);
        chk("idle_nBusRd", oRd, 1);
        chk("idle_rspValid", oRv, 0);
        chk("idle_busAddr", oAddr, mAddr[sel]);
        chk("idle_rspData", oRsp, mRsp[sel]);
        reqValid = 1'b0;
      end
      cur = oWr & oRd;
      if (prevStrobe && !cur) pulses++;
      prevStrobe = cur;
      if (n < total) begin
        @(posedge clk); #1;
      end
    end
  endtask

  typedef struct {
    bit          write;
    logic [12:0] addr;
    logic [7:0]  data;
    logic [12:0] len;
    logic [7:0]  rd;
    bit          noise;
    int          expPulses;
    logic [12:0] expEnd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int pulses;
    vecs[0] = '{1'b1, 13'h0123, 8'h5A, 13'd0, 8'h00, 1'b0, 1, 13'h0123};
    vecs[1] = '{1'b0, 13'h0ABC, 8'h00, 13'd0, 8'hC3, 1'b0, 1, 13'h0ABC};
    vecs[2] = '{1'b1, 13'h1FFE, 8'h20, 13'd3, 8'h00, 1'b0, 4, 13'h0001};
    vecs[3] = '{1'b1, 13'h0100, 8'h77, 13'd2, 8'h00, 1'b1, 3, 13'h0102};
    vecs[4] = '{1'b0, 13'h0200, 8'h00, 13'd0, 8'h3C, 1'b0, 1, 13'h0200};
    vecs[5] = '{1'b1, 13'h1FFF, 8'hA5, 13'd0, 8'h00, 1'b0, 1, 13'h1FFF};
    clearModel();

    // Reset values while nrst is held low.
    sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reqReady", oReady, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_busDataOe", oOe, 0);
    chk("rst_nBusRd", oRd, 1);
    chk("rst_nBusWr", oWr, 1);
    chk("rst_rspValid", oRv, 0);
    chk("rst_busAddr", oAddr, 0);
    chk("rst_busDataOut", oDout, 0);
    chk("rst_rspData", oRsp, 0);
    nrst = 1'b1;
    #1;
    chk("rst_release_reqReady", oReady, 1);

    // Directed table; entry 3 carries request noise, entry 4 follows it
    // back-to-back in the first idle cycle.
    for (int i = 0; i < 6; i++) begin
      doCmd(vecs[i].write, vecs[i].addr, vecs[i].data, vecs[i].len, vecs[i].rd,
            vecs[i].noise, pulses);
      chk("strobe_pulses", pulses, vecs[i].expPulses);
      chk("end_addr", oAddr, vecs[i].expEnd);
    end

    // Reset during cycle T4 of a write.
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 13'h0040; reqData = 8'h11; reqLen = 13'd5;
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abortw_strobe_low_T4", oWr, 0);
    nrst = 1'b0;
    @(posedge clk); #1;
    chk("abortw_nBusWr", oWr, 1);
    chk("abortw_busDataOe", oOe, 0);
    chk("abortw_busy", oBusy, 0);
    chk("abortw_reqReady_in_rst", oReady, 0);
    chk("abortw_busAddr", oAddr, 0);
    nrst = 1'b1;
    #1;
    chk("abortw_reqReady_release", oReady, 1);
    clearModel();

    // Reset landing on the edge that would capture read data.
    busDataIn = 8'hEE;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 13'h0777;
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("abortr_strobe_low_T6", oRd, 0);
    nrst = 1'b0;
    @(posedge clk); #1;
    chk("abortr_rspValid", oRv, 0);
    chk("abortr_rspData", oRsp, 0);
    chk("abortr_nBusRd", oRd, 1);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("abortr_rspValid_after", oRv, 0);
    chk("abortr_reqReady", oReady, 1);
    clearModel();

    // Randomized commands on the default timing.
    for (int i = 0; i < 20; i++) begin
      bit w;
      w = 1'($urandom_range(0, 1));
      doCmd(w, 13'($urandom), 8'($urandom), 13'($urandom_range(0, 5)), 8'($urandom),
            1'($urandom_range(0, 1)), pulses);
    end

    // Timing sweep on the fastest and slowest parameter sets.
    for (int inst = 1; inst < 3; inst++) begin
      sel = inst;
      doCmd(1'b1, 13'h1FFF, 8'h3E, 13'd2, 8'h00, 1'b0, pulses);
      chk("sweep_write_pulses", pulses, 3);
      doCmd(1'b0, 13'h0010, 8'h00, 13'd0, 8'h96, 1'b0, pulses);
      chk("sweep_read_pulses", pulses, 1);
      for (int i = 0; i < 3; i++) begin
        doCmd(1'($urandom_range(0, 1)), 13'($urandom), 8'($urandom),
              13'($urandom_range(0, 2)), 8'($urandom), 1'b1, pulses);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
